// File: rtl/prom_nibble_loader_if.sv
// Download handshake bundle for the PROM nibble loader.
// The master drives bytes and the slave (loader) answers with ready.
interface prom_nibble_loader_if;
   logic       dl_start;
   logic       dl_valid;
   logic [7:0] dl_data;
   logic       dl_ready;

   modport master (
      output dl_start,
      output dl_valid,
      output dl_data,
      input  dl_ready
   );

   modport slave (
      input  dl_start,
      input  dl_valid,
      input  dl_data,
      output dl_ready
   );
endinterface

// File: rtl/prom_nibble_loader.sv
// Runtime-loaded 2**AW x DW PROM: stores the low nibble of each download byte.
// Optional load checksum (sum_err) is built when PROM_CHECKSUM_EN is defined.
module prom_nibble_loader #(
   parameter int         AW         = 8,
   parameter int         DW         = 4,
   parameter logic [7:0] EXPECT_SUM = 8'h00
) (
   input  logic          clk,
   input  logic          reset,
   prom_nibble_loader_if.slave dl,
   output logic          dl_done,
   output logic          busy,
   output logic          ovf_err,
   input  logic [AW-1:0] addr,
   input  logic          cs,
   output logic [DW-1:0] dout
`ifdef PROM_CHECKSUM_EN
   ,
   output logic          sum_err
`endif
);

   localparam int            DEPTH = 2**AW;
   localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } state_t;

   state_t        state, state_n;
   logic [AW-1:0] wptr, wptr_n;
   logic          we;
   logic          fin;
   logic          ovf_set;
   logic          ovf_clr;

   logic [DW-1:0] mem [DEPTH];

   // Upper download bits are intentionally discarded.
   logic unused_hi;
   assign unused_hi = ^dl.dl_data[7:DW];

   assign dl.dl_ready = (state == LOAD);
   assign busy        = (state == LOAD);
   assign dl_done     = (state == DONE);

   // State and write pointer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         wptr  <= '0;
      end else begin
         state <= state_n;
         wptr  <= wptr_n;
      end
   end

   // Next state; a restart beats any same-cycle byte.
   always_comb begin
      state_n = state;
      wptr_n  = wptr;
      we      = 1'b0;
      fin     = 1'b0;
      ovf_set = 1'b0;
      ovf_clr = 1'b0;
      unique case (state)
         IDLE: begin
            if (dl.dl_start) begin
               state_n = LOAD;
               wptr_n  = '0;
            end
         end
         LOAD: begin
            if (dl.dl_start) begin
               wptr_n = '0;
            end else if (dl.dl_valid) begin
               we     = 1'b1;
               wptr_n = wptr + AW'(1);
               if (wptr == LAST) begin
                  state_n = DONE;
                  fin     = 1'b1;
               end
            end
         end
         DONE: begin
            if (dl.dl_start) begin
               state_n = LOAD;
               wptr_n  = '0;
               ovf_clr = 1'b1;
            end else if (dl.dl_valid) begin
               ovf_set = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Sticky overflow flag for bytes offered after a full load.
   always_ff @(posedge clk) begin
      if (reset)        ovf_err <= 1'b0;
      else if (ovf_clr) ovf_err <= 1'b0;
      else if (ovf_set) ovf_err <= 1'b1;
   end

   // PROM array write; contents survive reset.
   always_ff @(posedge clk) begin
      if (we) mem[wptr] <= dl.dl_data[DW-1:0];
   end

   // Registered read; blanked during a load, old data on collision.
   always_ff @(posedge clk) begin
      if (reset)   dout <= '0;
      else if (cs) dout <= busy ? '0 : mem[addr];
   end

`ifdef PROM_CHECKSUM_EN
   logic [7:0] acc, acc_next;

   assign acc_next = acc + 8'(dl.dl_data[DW-1:0]);

   // Running nibble sum, judged on the final write.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= '0;
         sum_err <= 1'b0;
      end else if (dl.dl_start) begin
         acc     <= '0;
         sum_err <= 1'b0;
      end else begin
         if (we)  acc     <= acc_next;
         if (fin) sum_err <= (acc_next != EXPECT_SUM);
      end
   end
`endif

endmodule

// File: tb/tb_prom_nibble_loader.sv
// Self-checking bench for prom_nibble_loader: vector table, directed
// sequences and random traffic against a behavioural PROM model.
module tb_prom_nibble_loader;

   logic       clk;
   logic       reset;
   logic       dl_done;
   logic       busy;
   logic       ovf_err;
   logic [7:0] addr;
   logic       cs;
   logic [3:0] dout;
`ifdef PROM_CHECKSUM_EN
   logic       sum_err;
`endif

   prom_nibble_loader_if dl ();

   prom_nibble_loader dut (
      .clk     (clk),
      .reset   (reset),
      .dl      (dl),
      .dl_done (dl_done),
      .busy    (busy),
      .ovf_err (ovf_err),
      .addr    (addr),
      .cs      (cs),
      .dout    (dout)
`ifdef PROM_CHECKSUM_EN
      ,
      .sum_err (sum_err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_fail = 0;

   // behavioural model
   int  mm [256];
   bit  mk [256];
   bit  m_load, m_done, m_ovf, m_serr, m_dk;
   int  m_cnt, m_sum, m_dout;
   bit  mchk;
   bit  last_xfer;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit r, input bit st, input bit v,
                      input logic [7:0] d, input bit c,
                      input logic [7:0] a);
      int rd;
      bit rk;
      reset       = r;
      dl.dl_start = st;
      dl.dl_valid = v;
      dl.dl_data  = d;
      cs          = c;
      addr        = a;
      if (c) begin
         if (m_load) begin
            rd = 0;
            rk = 1'b1;
         end else begin
            rd = mm[a];
            rk = mk[a];
         end
      end else begin
         rd = m_dout;
         rk = m_dk;
      end
      last_xfer = !r && !st && m_load && v;
      if (r) begin
         m_load = 0; m_done = 0; m_ovf = 0; m_serr = 0;
         m_cnt = 0; m_sum = 0; m_dout = 0; m_dk = 1;
      end else begin
         m_dout = rd;
         m_dk   = rk;
         if (st) begin
            m_load = 1; m_done = 0; m_ovf = 0;
            m_cnt = 0; m_sum = 0; m_serr = 0;
         end else if (m_load && v) begin
            mm[m_cnt] = int'(d) % 16;
            mk[m_cnt] = 1'b1;
            m_sum     = m_sum + int'(d) % 16;
            m_cnt     = m_cnt + 1;
            if (m_cnt == 256) begin
               m_load = 0;
               m_done = 1;
               m_serr = (m_sum % 256) != 0;
            end
         end else if (m_done && v) begin
            m_ovf = 1;
         end
      end
      @(posedge clk);
      #1;
      if (mchk) begin
         chk("ready", int'(dl.dl_ready), int'(m_load));
         chk("busy", int'(busy), int'(m_load));
         chk("done", int'(dl_done), int'(m_done));
         chk("ovf", int'(ovf_err), int'(m_ovf));
         if (m_dk) chk("dout", int'(dout), m_dout);
`ifdef PROM_CHECKSUM_EN
         chk("sum_err", int'(sum_err), int'(m_serr));
`endif
      end
   endtask

   typedef struct {
      bit         r, st, v;
      logic [7:0] d;
      bit         c;
      logic [7:0] a;
      bit         e_rdy, e_done, e_busy, e_ovf;
      logic [3:0] e_dout;
   } vec_t;

   vec_t tbl [11];

   initial begin
      int nwr;
      int k;
      bit early;
      int save0;
      int hold;

      for (int i = 0; i < 256; i++) begin
         mm[i] = 0;
         mk[i] = 1'b0;
      end
      reset = 1'b1; dl.dl_start = 0; dl.dl_valid = 0;
      dl.dl_data = 0; cs = 0; addr = 0;

      //         r st v d      c a      rdy dn by ov dout
      tbl[0]  = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 4'h0};
      tbl[1]  = '{0, 0, 1, 8'h55, 0, 8'h00, 0, 0, 0, 0, 4'h0};
      tbl[2]  = '{0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 4'h0};
      tbl[3]  = '{0, 0, 1, 8'hA3, 0, 8'h00, 1, 0, 1, 0, 4'h0};
      tbl[4]  = '{0, 0, 1, 8'hA4, 1, 8'h00, 1, 0, 1, 0, 4'h0};
      tbl[5]  = '{0, 1, 1, 8'hFF, 0, 8'h00, 1, 0, 1, 0, 4'h0};
      tbl[6]  = '{0, 0, 1, 8'hA9, 0, 8'h00, 1, 0, 1, 0, 4'h0};
      tbl[7]  = '{1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0, 4'h0};
      tbl[8]  = '{0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0, 4'h9};
      tbl[9]  = '{0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0, 0, 4'h4};
      tbl[10] = '{0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 4'h4};

      mchk = 1'b0;
      foreach (tbl[i]) begin
         cyc(tbl[i].r, tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].a);
         chk($sformatf("tbl%0d_ready", i), int'(dl.dl_ready), int'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_done", i), int'(dl_done), int'(tbl[i].e_done));
         chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_ovf", i), int'(ovf_err), int'(tbl[i].e_ovf));
         chk($sformatf("tbl%0d_dout", i), int'(dout), int'(tbl[i].e_dout));
      end
      mchk = 1'b1;

      // full load with dl_valid held high
      cyc(0, 1, 0, 8'h00, 0, 8'h00);
      for (int i = 0; i < 256; i++)
         cyc(0, 0, 1, 8'hA0 | (8'(i) & 8'h0F), 0, 8'h00);
      chk("t1_done", int'(dl_done), 1);
      cyc(0, 0, 0, 8'h00, 1, 8'h05);
      chk("t1_dout5", int'(dout), 5);

      // valid one cycle in three
      cyc(0, 1, 0, 8'h00, 0, 8'h00);
      nwr = 0; k = 0; early = 0;
      while (m_load && k < 2000) begin
         cyc(0, 0, (k % 3) == 0, 8'($urandom), 0, 8'h00);
         if (last_xfer) nwr++;
         if (nwr < 256 && !busy) early = 1;
         k++;
      end
      chk("t2_timeout", int'(k < 2000), 1);
      chk("t2_writes", nwr, 256);
      chk("t2_early_drop", int'(early), 0);
      chk("t2_done", int'(dl_done), 1);
      save0 = mm[0];

      // overflow in DONE
      cyc(0, 0, 1, 8'hFF, 0, 8'h00);
      chk("t3_ovf", int'(ovf_err), 1);
      cyc(0, 0, 0, 8'h00, 1, 8'h00);
      chk("t3_mem0", int'(dout), save0);
      cyc(0, 1, 0, 8'h00, 0, 8'h00);
      chk("t3_ovf_clr", int'(ovf_err), 0);

      // restart mid-load drops the coincident byte
      for (int i = 0; i < 100; i++)
         cyc(0, 0, 1, 8'($urandom), 0, 8'h00);
      cyc(0, 1, 1, 8'h07, 0, 8'h00);
      cyc(0, 0, 1, 8'h0C, 1, 8'h00);
      chk("t4_busy_read", int'(dout), 0);
      for (int i = 0; i < 255; i++)
         cyc(0, 0, 1, 8'($urandom), 0, 8'h00);
      chk("t4_done", int'(dl_done), 1);
      cyc(0, 0, 0, 8'h00, 1, 8'h00);
      chk("t4_addr0", int'(dout), 12);

      // reset mid-load
      cyc(0, 1, 0, 8'h00, 0, 8'h00);
      for (int i = 0; i < 50; i++)
         cyc(0, 0, 1, 8'($urandom), 0, 8'h00);
      cyc(1, 0, 0, 8'h00, 0, 8'h00);
      cyc(0, 0, 0, 8'h00, 1, 8'd10);
      chk("t5_addr10", int'(dout), mm[10]);
      chk("t5_done", int'(dl_done), 0);
      hold = int'(dout);
      cyc(0, 0, 0, 8'h00, 1, 8'd200);
      chk("t5_addr200", int'(dout), mm[200]);
      hold = int'(dout);
      cyc(0, 0, 0, 8'h00, 0, 8'd33);
      chk("t5_hold", int'(dout), hold);

`ifdef PROM_CHECKSUM_EN
      cyc(0, 1, 0, 8'h00, 0, 8'h00);
      for (int i = 0; i < 256; i++)
         cyc(0, 0, 1, 8'h01, 0, 8'h00);
      chk("t6_sum_ok", int'(sum_err), 0);
      cyc(0, 1, 0, 8'h00, 0, 8'h00);
      for (int i = 0; i < 256; i++)
         cyc(0, 0, 1, (i == 77) ? 8'h02 : 8'h01, 0, 8'h00);
      chk("t6_sum_bad", int'(sum_err), 1);
`endif

      // random traffic against the model
      for (int i = 0; i < 4000; i++)
         cyc(($urandom % 600) == 0, ($urandom % 700) == 0,
             $urandom % 2, 8'($urandom), $urandom % 2, 8'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
